// File: rtl/alu_control_seq.sv
// Registered EX-stage ALU control decoder with DIVU sequencing and hazard stall.
// Optional sticky illegal-funct flag enabled by ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_control_seq #(
  parameter int FUNCT_W    = 6,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               flush,
  output logic [2:0]         alu_op,
  output logic               sht_en,
  output logic               div_start,
  output logic [1:0]         mux_sel,
  output logic               stall,
  output logic               div_busy,
  output logic               hilo_valid,
  output logic               illegal
);

  localparam logic [FUNCT_W-1:0] F_SLL  = FUNCT_W'(0);
  localparam logic [FUNCT_W-1:0] F_MFHI = FUNCT_W'(16);
  localparam logic [FUNCT_W-1:0] F_MFLO = FUNCT_W'(18);
  localparam logic [FUNCT_W-1:0] F_DIVU = FUNCT_W'(27);
  localparam logic [FUNCT_W-1:0] F_ADD  = FUNCT_W'(32);
  localparam logic [FUNCT_W-1:0] F_SUB  = FUNCT_W'(34);
  localparam logic [FUNCT_W-1:0] F_AND  = FUNCT_W'(36);
  localparam logic [FUNCT_W-1:0] F_OR   = FUNCT_W'(37);
  localparam logic [FUNCT_W-1:0] F_SLT  = FUNCT_W'(42);

  typedef enum logic {IDLE, DIV_RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hilo_valid_q, hilo_valid_d;
  logic               div_start_q, div_start_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic               sht_en_q, sht_en_d;
  logic [1:0]         mux_sel_q, mux_sel_d;

  logic [2:0]         dec_alu_op;
  logic               dec_sht_en;
  logic [1:0]         dec_mux_sel;
  logic               is_divu, is_mf, accepted;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic               dec_illegal;
  logic               illegal_q, illegal_d;
`endif

  always_comb begin
    dec_alu_op  = '0;
    dec_sht_en  = 1'b0;
    dec_mux_sel = '0;
    is_divu     = 1'b0;
    is_mf       = 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    dec_illegal = 1'b0;
`endif
    case (funct)
      F_AND:  dec_alu_op = 3'd0;
      F_OR:   dec_alu_op = 3'd1;
      F_ADD:  dec_alu_op = 3'd2;
      F_SUB:  dec_alu_op = 3'd3;
      F_SLT:  dec_alu_op = 3'd4;
      F_SLL: begin
        dec_sht_en  = 1'b1;
        dec_mux_sel = 2'd1;
      end
      F_DIVU: is_divu = 1'b1;
      F_MFHI: begin
        dec_mux_sel = 2'd2;
        is_mf       = 1'b1;
      end
      F_MFLO: begin
        dec_mux_sel = 2'd3;
        is_mf       = 1'b1;
      end
      default: begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        dec_illegal = 1'b1;
`endif
      end
    endcase
  end

  assign div_busy = (state_q == DIV_RUN);
  // Only ops that touch the divider or HI/LO conflict with a running divide.
  assign stall    = valid_in & ~flush & div_busy & (is_divu | is_mf);
  assign accepted = valid_in & ~flush & ~stall;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hilo_valid_d = hilo_valid_q;
    div_start_d  = 1'b0;
    alu_op_d     = '0;
    sht_en_d     = 1'b0;
    mux_sel_d    = '0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    illegal_d    = illegal_q | (accepted & dec_illegal);
`endif
    if (accepted) begin
      alu_op_d  = dec_alu_op;
      sht_en_d  = dec_sht_en;
      mux_sel_d = dec_mux_sel;
    end
    if (state_q == IDLE) begin
      if (accepted && is_divu) begin
        state_d      = DIV_RUN;
        cnt_d        = CNT_W'(DIV_CYCLES);
        hilo_valid_d = 1'b0;
        div_start_d  = 1'b1;
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d      = IDLE;
        hilo_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hilo_valid_q <= 1'b0;
      div_start_q  <= 1'b0;
      alu_op_q     <= '0;
      sht_en_q     <= 1'b0;
      mux_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hilo_valid_q <= hilo_valid_d;
      div_start_q  <= div_start_d;
      alu_op_q     <= alu_op_d;
      sht_en_q     <= sht_en_d;
      mux_sel_q    <= mux_sel_d;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign alu_op     = alu_op_q;
  assign sht_en     = sht_en_q;
  assign mux_sel    = mux_sel_q;
  assign div_start  = div_start_q;
  assign hilo_valid = hilo_valid_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed self-checking bench for alu_control_seq (DIV_CYCLES = 32).
module tb_alu_control_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic [5:0] funct = '0;
  logic       flush = 1'b0;
  logic [2:0] alu_op;
  logic       sht_en, div_start, stall, div_busy, hilo_valid, illegal;
  logic [1:0] mux_sel;

  int checks = 0;
  int errors = 0;
  int n;

  alu_control_seq #(.FUNCT_W(6), .DIV_CYCLES(32), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .funct(funct), .flush(flush),
    .alu_op(alu_op), .sht_en(sht_en), .div_start(div_start), .mux_sel(mux_sel),
    .stall(stall), .div_busy(div_busy), .hilo_valid(hilo_valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic fl);
    valid_in = v;
    funct    = f;
    flush    = fl;
    #1;
  endtask

  initial begin
    #12;
    check("rst_alu_op", alu_op, 0);
    check("rst_busy", div_busy, 0);
    check("rst_hilo", hilo_valid, 0);
    check("rst_start", div_start, 0);
    rst = 1'b0;
    tick();

    // ALU / shifter stream
    drive(1, 6'd32, 0); check("add_stall", stall, 0); tick();
    check("add_op", alu_op, 2); check("add_mux", mux_sel, 0);
    drive(1, 6'd34, 0); tick(); check("sub_op", alu_op, 3);
    drive(1, 6'd42, 0); tick(); check("slt_op", alu_op, 4);
    drive(1, 6'd37, 0); tick(); check("or_op", alu_op, 1);
    drive(1, 6'd0, 0);  check("sll_stall", stall, 0); tick();
    check("sll_sht", sht_en, 1); check("sll_mux", mux_sel, 1); check("sll_op", alu_op, 0);
    drive(0, 6'd32, 0); tick();
    check("bubble_op", alu_op, 0); check("bubble_sht", sht_en, 0);

    // DIVU accepted at T
    drive(1, 6'd27, 0); check("divu_idle_stall", stall, 0); tick();
    check("T1_start", div_start, 1); check("T1_busy", div_busy, 1); check("T1_hilo", hilo_valid, 0);
    drive(0, 6'd0, 0); tick();
    check("T2_start", div_start, 0); check("T2_busy", div_busy, 1);
    drive(1, 6'd32, 0); check("T2_add_stall", stall, 0); tick();
    check("T3_add_op", alu_op, 2);
    drive(0, 6'd0, 0); tick();
    tick();
    drive(1, 6'd18, 0); check("T5_mflo_stall", stall, 1);
    n = 0;
    while (stall === 1'b1 && n < 200) begin n++; tick(); end
    check("mflo_stall_cycles", n, 28);
    check("T33_hilo", hilo_valid, 1); check("T33_busy", div_busy, 0); check("T33_stall", stall, 0);
    tick();
    check("mflo_mux", mux_sel, 3);
    drive(0, 6'd0, 0);

    // Back-to-back DIVU accepted at U
    drive(1, 6'd27, 0); tick();
    check("U1_start", div_start, 1);
    drive(0, 6'd0, 0); tick();
    tick();
    drive(1, 6'd27, 0); check("U3_divu_stall", stall, 1);
    n = 0;
    while (stall === 1'b1 && n < 200) begin n++; tick(); end
    check("divu2_stall_cycles", n, 30);
    check("U33_hilo", hilo_valid, 1); check("U33_start", div_start, 0);
    tick();
    check("div2_start", div_start, 1); check("div2_hilo", hilo_valid, 0); check("div2_busy", div_busy, 1);
    drive(0, 6'd0, 0);
    tick();
    check("div2_start_once", div_start, 0);
    drive(1, 6'd16, 1); check("flush_mfhi_nostall", stall, 0);
    drive(0, 6'd0, 0);
    repeat (8) tick();

    // Asynchronous reset mid-divide
    #2 rst = 1'b1;
    #1;
    check("arst_busy", div_busy, 0); check("arst_hilo", hilo_valid, 0);
    check("arst_start", div_start, 0); check("arst_mux", mux_sel, 0);
    #1 rst = 1'b0;
    tick();
    drive(1, 6'd16, 0); check("mfhi_nostall", stall, 0); tick();
    check("mfhi_mux", mux_sel, 2);

    // Flushed DIVU
    drive(1, 6'd27, 1); check("flush_stall", stall, 0); tick();
    check("flush_start", div_start, 0); check("flush_busy", div_busy, 0);
    check("flush_mux", mux_sel, 0);

    // Illegal funct
    drive(1, 6'd63, 0); check("ill_stall", stall, 0); tick();
    check("ill_op", alu_op, 0); check("ill_mux", mux_sel, 0); check("ill_sht", sht_en, 0);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    check("ill_flag", illegal, 1);
    drive(0, 6'd0, 0); tick(); tick();
    check("ill_sticky", illegal, 1);
`else
    check("ill_tied", illegal, 0);
    drive(0, 6'd0, 0); tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Registered successor to the combinational ALU control decoder in the EX stage of the 5-stage MIPS pipeline.
- Decodes the R-type funct field into per-unit controls for the ALU, shifter, divider and result mux.
- Owns sequencing of the multi-cycle DIVU: start pulse, cycle counter, HI/LO validity.
- Raises a pipeline stall on structural/data hazards against the running divide.

Parameters:
- FUNCT_W, 6, width of funct input.
- DIV_CYCLES, 32, cycles the divider needs from start to HI/LO valid; legal range 2..127.
- CNT_W, 7, counter width; must hold DIV_CYCLES.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- valid_in  input  1  EX-stage instruction is a valid R-type.
- funct  input  FUNCT_W  funct field.
- flush  input  1  squash the instruction currently in EX.
- alu_op  output  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT; 0 when unused.
- sht_en  output  1  shifter performs SLL.
- div_start  output  1  one-cycle divider start pulse.
- mux_sel  output  2  result select: 0 ALU, 1 SHT, 2 HI, 3 LO.
- stall  output  1  combinational; hold IF/ID/EX this cycle.
- div_busy  output  1  divide in progress.
- hilo_valid  output  1  HI/LO hold the result of the last DIVU.
- illegal  output  1  see Optional Feature.

Behaviour:
- Funct codes (decimal):
  - AND 36, OR 37, ADD 32, SUB 34, SLT 42 -> ALU, mux_sel 0.
  - SLL 0 -> sht_en, mux_sel 1.
  - DIVU 27 -> divider.
  - MFHI 16 -> mux_sel 2; MFLO 18 -> mux_sel 3.
  - Any other funct is illegal.
- Accept condition: accepted = valid_in & ~flush & ~stall.
- Output timing: alu_op, sht_en and mux_sel are registered, with 1-cycle latency from an accepted instruction.
- Non-accepted cycle: the next registered outputs are all zero. This is a NOP bubble: alu_op 0, sht_en 0, mux_sel 0.
- Reset values: all outputs 0, FSM IDLE, counter 0, hilo_valid 0.
- FSM states: IDLE, DIV_RUN.
  - IDLE + accepted DIVU:
    - div_start = 1 in the following cycle, for exactly one cycle.
    - counter loads DIV_CYCLES.
    - hilo_valid clears to 0.
    - Go to DIV_RUN.
  - DIV_RUN: counter decrements each cycle. When counter == 1, the next state is IDLE and hilo_valid is set to 1.
  - div_busy = 1 exactly while the state is DIV_RUN.
  - The DIVU result is therefore available DIV_CYCLES cycles after div_start.
- Stall rules (combinational, from current state and inputs):
  - stall = valid_in & ~flush & div_busy & (funct is DIVU, MFHI or MFLO).
  - ALU, SLL and illegal ops never stall; they proceed in parallel with the divide.
  - When the divide completes (state returns to IDLE), stall drops that same cycle and the held instruction is accepted.
- Flush:
  - Squashes only the instruction presented in that cycle: no div_start, no stall.
  - Does not abort a divide already in DIV_RUN.
- Back-to-back DIVU: the second DIVU stalls until IDLE, then is accepted. hilo_valid clears again on its acceptance.
- Reset mid-divide: rst forces IDLE immediately and asynchronously. div_busy, div_start and hilo_valid go to 0; the counter is cleared.
- MFHI/MFLO with hilo_valid = 0 and not busy (e.g. after reset): accepted normally, no stall. Software result is undefined.

Optional Feature:
- Macro: ALU_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An accepted illegal funct sets illegal = 1 on the next cycle (registered).
  - illegal is sticky until rst.
  - The instruction is still issued as a NOP bubble.
- Undefined: illegal is tied to 0 and illegal functs are silently treated as NOP bubbles.

Test Plan:
- Reset then ADD (32), SUB (34), SLT (42), SLL (0), one per cycle -> next-cycle alu_op 2,3,4 then sht_en=1 with mux_sel=1; stall never asserts.
- DIVU (27) with DIV_CYCLES=32 accepted at cycle T:
  - div_start high only at T+1; div_busy high T+1..T+32; hilo_valid=1 from T+33.
  - ADD at T+2 issues without stall.
- MFLO (18) presented at T+5 during the divide -> stall held until the state returns to IDLE, then accepted; next cycle mux_sel=3.
- Second DIVU at T+3 -> stalls until completion, then hilo_valid goes 1 then 0 on acceptance; div_start pulses once more.
- rst asserted asynchronously mid-divide at T+10 -> div_busy, hilo_valid and all outputs 0 immediately; a subsequent MFHI is not stalled.
- flush with valid DIVU -> no div_start, state stays IDLE. With ALU_CTRL_ILLEGAL_TRAP_EN, funct 63 -> illegal=1 next cycle and it stays 1.
